gate_sweep_checker: RTL
=======================

# gate_sweep_checker

Self-checking truth-table sweeper for small switch-level and gate-level cells such as nmos OR3/NOR3 networks. It drives every input combination onto the cell under test, waits a fixed settle time, samples the cell's single output, and compares it against an expected truth table given as a parameter. It is the response and verification side of our gate characterisation setup, usable in simulation and on FPGA against an external cell.

## Interface
Parameters:
- N_IN, 3: number of cell inputs; the sweep covers 2**N_IN vectors.
- SETTLE, 5: clock cycles each vector is held before sampling; must be >= 3 to cover the synchroniser.
- EXPECT, 8'hFE: expected truth table, 2**N_IN bits; bit i is the expected output for x == i. The default is OR3.

Ports (name, direction, width, meaning):
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request a sweep; sampled only in IDLE
- y_in  in  1  cell output; asynchronous to clk
- x  out  N_IN  vector driven to the cell
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes
- pass  out  1  high when the last sweep had zero mismatches
- err_mask  out  2**N_IN  bit i set when vector i mismatched
- err_count  out  N_IN+1  number of mismatching vectors
- observed  out  2**N_IN  captured output per vector; present only with the macro

## Operation
- y_in passes through a 2-flop synchroniser to produce y_s. Only y_s is compared.
- FSM states: IDLE, WAIT, FIN.
- IDLE, start=1: x<=0, cnt<=0, err_mask<=0, err_count<=0, pass<=0, busy<=1; go to WAIT.
- WAIT, cnt<SETTLE-1: cnt<=cnt+1.
- WAIT, cnt==SETTLE-1:
  - Compare y_s with EXPECT[x].
  - On mismatch, set err_mask[x] and increment err_count.
  - If x != 2**N_IN-1: x<=x+1, cnt<=0, stay in WAIT.
  - Otherwise go to FIN and set busy<=0 and done<=1. pass is set from the final error state, including the last comparison.
- FIN: done returns to 0 and the FSM goes to IDLE. x holds its last value.
- start while busy or in FIN is ignored. It is not queued.
- Results (pass, err_mask, err_count, observed) hold until the next accepted start.
- err_count saturation is unnecessary: its maximum is 2**N_IN, which fits in N_IN+1 bits.

## Timing
- Reset values: x=0, busy=0, done=0, pass=0, err_mask=0, err_count=0, observed=0, synchroniser=0, state IDLE.
- E0 is the edge at which start is accepted.
- Vector i is driven from edge E0+i*SETTLE and sampled at edge E0+(i+1)*SETTLE.
- Completion edge is Ec = E0 + 2**N_IN*SETTLE (E40 with the defaults).
  - done is high for exactly the cycle after Ec.
  - busy is high from E0 until Ec.
  - Results are valid from Ec.
- Sampling latency: y_in must be stable by 2 cycles before the sampling edge.
- Back-to-back operation: start held high is re-accepted at Ec+2 (IDLE). The minimum sweep period is 2**N_IN*SETTLE+2 cycles.
- Reset asserted mid-sweep: all outputs return immediately to reset values and no done pulse is produced. The first start after release begins a clean sweep.

## Configuration
- GATE_SWEEP_OBSERVED_EN defined:
  - The observed port and register exist.
  - observed[x] <= y_s at each sampling edge.
  - observed is cleared on accepted start.
- Undefined: the observed port, its register and its logic are absent. All other behaviour is identical.

## Structure
- Shared package gate_sweep_pkg holds:
  - the FSM state encoding (IDLE, WAIT, FIN)
  - the default expected tables as named constants: OR3_TT=8'hFE, NOR3_TT=8'h01, AND3_TT=8'h80
- One sub-module, sync2: a generic 2-flop synchroniser reset by rst_n to 0, instantiated for y_in.

## Test plan
- Cell model y=|x, defaults, pulse start: done at Ec=E0+40, pass=1, err_mask=8'h00, err_count=0, x stepped 0..7 every 5 cycles.
- y stuck at 0: pass=0, err_mask=8'hFE, err_count=7. Stuck at 1: err_mask=8'h01, err_count=1.
- EXPECT=NOR3_TT against a NOR3 model (y=~|x): pass=1. The same table against an OR3 model: err_mask=8'hFF, err_count=8.
- Pulse start again at E0+10 and E0+20 during a sweep: no restart, single done at E0+40. Start held high: next sweep accepted at E0+42.
- Assert rst_n low at E0+12 for 3 cycles: all outputs 0, no done. After release, a start yields the normal pass=1 result.
- With GATE_SWEEP_OBSERVED_EN and the OR3 model: observed=8'hFE at done. Without the macro, the build has no observed port and the other results are unchanged.

Source files
------------

// File: rtl/gate_sweep_checker_pkg.sv
// gate_sweep_pkg: shared FSM state encoding and the standard expected
// truth tables used by the gate sweep checker.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIN  = 2'd2
    } sweep_state_t;

    // Bit i is the expected cell output when the applied vector equals i.
    localparam logic [7:0] OR3_TT  = 8'hFE;
    localparam logic [7:0] NOR3_TT = 8'h01;
    localparam logic [7:0] AND3_TT = 8'h80;

endpackage

// File: rtl/gate_sweep_checker_sync2.sv
// sync2: generic two-flop synchroniser, cleared to zero by rst_n.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give a metastable first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: walks every input vector onto a small cell, holds each
// for SETTLE cycles, samples the synchronised cell output and records any
// mismatch against the EXPECT truth table.
// Optional feature: define GATE_SWEEP_OBSERVED_EN to add the 'observed' port,
// which captures the sampled output for every vector.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int                    N_IN   = 3,
    parameter int                    SETTLE = 5,
    parameter logic [(2**N_IN)-1:0]  EXPECT = OR3_TT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  y_in,
    output logic [N_IN-1:0]       x,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [(2**N_IN)-1:0]  err_mask,
`ifdef GATE_SWEEP_OBSERVED_EN
    output logic [(2**N_IN)-1:0]  observed,
`endif
    output logic [N_IN:0]         err_count
);

    localparam int NVEC  = 2**N_IN;
    localparam int CNT_W = $clog2(SETTLE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0]  X_LAST   = N_IN'(NVEC - 1);
    localparam logic [N_IN-1:0]  X_ONE    = N_IN'(1);
    localparam logic [N_IN:0]    ERR_ONE  = (N_IN + 1)'(1);

    sweep_state_t r_state;
    sweep_state_t w_nextState;

    logic [N_IN-1:0]  r_x,        w_nextX;
    logic [CNT_W-1:0] r_cnt,      w_nextCnt;
    logic             r_busy,     w_nextBusy;
    logic             r_done,     w_nextDone;
    logic             r_pass,     w_nextPass;
    logic [NVEC-1:0]  r_errMask,  w_nextErrMask;
    logic [N_IN:0]    r_errCount, w_nextErrCount;
`ifdef GATE_SWEEP_OBSERVED_EN
    logic [NVEC-1:0]  r_observed, w_nextObserved;
`endif

    logic w_ySync;
    logic w_mismatch;

    sync2 #(
        .WIDTH (1)
    ) u_ySync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (y_in),
        .o_q   (w_ySync)
    );

    // Register every piece of sweep state; reset returns all results to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_x        <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_errMask  <= '0;
            r_errCount <= '0;
`ifdef GATE_SWEEP_OBSERVED_EN
            r_observed <= '0;
`endif
        end else begin
            r_state    <= w_nextState;
            r_x        <= w_nextX;
            r_cnt      <= w_nextCnt;
            r_busy     <= w_nextBusy;
            r_done     <= w_nextDone;
            r_pass     <= w_nextPass;
            r_errMask  <= w_nextErrMask;
            r_errCount <= w_nextErrCount;
`ifdef GATE_SWEEP_OBSERVED_EN
            r_observed <= w_nextObserved;
`endif
        end
    end

    // Sweep sequencing: settle count, sample/compare on the last settle cycle, then advance or finish.
    always_comb begin
        w_nextState    = r_state;
        w_nextX        = r_x;
        w_nextCnt      = r_cnt;
        w_nextBusy     = r_busy;
        w_nextDone     = 1'b0;
        w_nextPass     = r_pass;
        w_nextErrMask  = r_errMask;
        w_nextErrCount = r_errCount;
`ifdef GATE_SWEEP_OBSERVED_EN
        w_nextObserved = r_observed;
`endif
        w_mismatch     = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState    = WAIT;
                    w_nextX        = '0;
                    w_nextCnt      = '0;
                    w_nextErrMask  = '0;
                    w_nextErrCount = '0;
                    w_nextPass     = 1'b0;
                    w_nextBusy     = 1'b1;
`ifdef GATE_SWEEP_OBSERVED_EN
                    w_nextObserved = '0;
`endif
                end
            end

            WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_mismatch = (w_ySync != EXPECT[r_x]);
                    if (w_mismatch) begin
                        w_nextErrMask[r_x] = 1'b1;
                        w_nextErrCount     = r_errCount + ERR_ONE;
                    end
`ifdef GATE_SWEEP_OBSERVED_EN
                    w_nextObserved[r_x] = w_ySync;
`endif
                    if (r_x != X_LAST) begin
                        w_nextX   = r_x + X_ONE;
                        w_nextCnt = '0;
                    end else begin
                        // The final comparison is folded in via w_nextErrCount.
                        w_nextState = FIN;
                        w_nextBusy  = 1'b0;
                        w_nextDone  = 1'b1;
                        w_nextPass  = (w_nextErrCount == '0);
                    end
                end else begin
                    w_nextCnt = r_cnt + CNT_ONE;
                end
            end

            FIN: begin
                w_nextState = IDLE;
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign x         = r_x;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_mask  = r_errMask;
    assign err_count = r_errCount;
`ifdef GATE_SWEEP_OBSERVED_EN
    assign observed  = r_observed;
`endif

endmodule
